// File: rtl/ccff_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ccff_loader                                                |
// | Description : Serial configuration-chain loader. Accepts bitstream words |
// |               over valid/ready, shifts them LSB-first into the chain     |
// |               head one bit per prog_clk, and assembles the bits leaving  |
// |               the chain tail into readback words.                        |
// | Ports       : prog_clk, pReset_n   - clock, async active-low reset       |
// |               start, abort         - begin a load / return to idle       |
// |               word_data/valid/ready - bitstream word handshake           |
// |               ccff_head, ccff_tail - chain serial in / serial out        |
// |               config_enable        - chain shift qualifier               |
// |               rb_data, rb_valid    - readback word and strobe            |
// |               busy, done           - status                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ccff_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1152,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              config_enable,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int BI_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BI_W-1:0]  c_bi_last  = BI_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] c_tot_last = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WORD_W-1:0] r_shreg;
  logic [WORD_W-1:0] r_rbreg;
  logic [WORD_W-1:0] r_rb_data;
  logic [WORD_W-1:0] w_rb_next;
  logic [BI_W-1:0]   r_bi;
  logic [CNT_W-1:0]  r_tot;
  logic              r_rb_valid;
  logic              w_chain_end;
  logic              w_word_end;

  assign w_chain_end = (r_tot == c_tot_last);
  assign w_word_end  = (r_bi == c_bi_last) || w_chain_end;

  // Readback word including the tail bit captured on the current edge, so the
  // completed word can be published on the same edge that finishes it.
  assign w_rb_next = r_rbreg | ({{(WORD_W-1){1'b0}}, ccff_tail} << r_bi);

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  if (word_valid) w_next = S_SHIFT;
      S_SHIFT: if (w_word_end) w_next = w_chain_end ? S_DONE : S_LOAD;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // abort overrides everything, including a coincident start
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_shreg    <= '0;
      r_rbreg    <= '0;
      r_rb_data  <= '0;
      r_bi       <= '0;
      r_tot      <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      // An aborted word is dropped silently: no datapath update, no strobe.
      if (!abort) begin
        case (r_state)
          S_IDLE: begin
            if (start) r_tot <= '0;
          end
          S_LOAD: begin
            if (word_valid) begin
              r_shreg <= word_data;
              r_bi    <= '0;
              r_rbreg <= '0;
            end
          end
          S_SHIFT: begin
            r_shreg <= r_shreg >> 1;
            r_rbreg <= w_rb_next;
            r_bi    <= r_bi + BI_W'(1);
            r_tot   <= r_tot + CNT_W'(1);
            if (w_word_end) begin
              // Bits above the last captured one stay 0 because rbreg was
              // cleared when the word was accepted.
              r_rb_data  <= w_rb_next;
              r_rb_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign word_ready    = (r_state == S_LOAD);
  assign config_enable = (r_state == S_SHIFT);
  assign ccff_head     = (r_state == S_SHIFT) ? r_shreg[0] : 1'b0;
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign rb_data       = r_rb_data;
  assign rb_valid      = r_rb_valid;

endmodule
`default_nettype wire

// File: tb/tb_ccff_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ccff_loader                                             |
// | Description : Bench for ccff_loader. Two instances (40-bit and 64-bit    |
// |               chains) each drive a behavioural chain model; expected     |
// |               chain contents, head stream, readback words and done       |
// |               timing are derived from the bitstream rules directly.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ccff_loader;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start_s [2];
  logic         abort_s [2];
  logic         wvalid  [2];
  logic         wready  [2];
  logic         head    [2];
  logic         tail    [2];
  logic         cen     [2];
  logic         rbv     [2];
  logic         busy    [2];
  logic         done_s  [2];
  logic [W-1:0] wdata   [2];
  logic [W-1:0] rbd     [2];
  logic [63:0]  chain   [2];
  logic [63:0]  pre_val [2];
  logic         pre_req [2];

  int n_chk  = 0;
  int n_fail = 0;

  ccff_loader #(.WORD_W(W), .CHAIN_LEN(40), .CNT_W(16)) u_dut40 (
    .prog_clk(clk), .pReset_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
    .word_data(wdata[0]), .word_valid(wvalid[0]), .word_ready(wready[0]),
    .ccff_head(head[0]), .ccff_tail(tail[0]), .config_enable(cen[0]),
    .rb_data(rbd[0]), .rb_valid(rbv[0]), .busy(busy[0]), .done(done_s[0])
  );

  ccff_loader #(.WORD_W(W), .CHAIN_LEN(64), .CNT_W(16)) u_dut64 (
    .prog_clk(clk), .pReset_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
    .word_data(wdata[1]), .word_valid(wvalid[1]), .word_ready(wready[1]),
    .ccff_head(head[1]), .ccff_tail(tail[1]), .config_enable(cen[1]),
    .rb_data(rbd[1]), .rb_valid(rbv[1]), .busy(busy[1]), .done(done_s[1])
  );

  function automatic int clen(input int d);
    return (d == 0) ? 40 : 64;
  endfunction

  // Chain model: head enters at the top bit, tail leaves from bit 0.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pre_req[i])
        chain[i] <= pre_val[i];
      else if (cen[i])
        chain[i] <= (chain[i] >> 1) | ({63'd0, head[i]} << (clen(i) - 1));
    end
  end
  assign tail[0] = chain[0][0];
  assign tail[1] = chain[1][0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete load: preload chain, start, feed two words (optionally with a
  // gap before the second one and spurious start pulses), then check.
  task automatic run_load(input int d, input logic [63:0] pre_in,
                          input logic [31:0] w0, input logic [31:0] w1,
                          input int gap, input bit spam, input string tag);
    int          len, nw, cyc, wp, gap_left, nrb, sc, done_cyc, idx;
    logic [63:0] pre, exp_chain;
    logic [31:0] wsel, exp_rb;
    len = clen(d);
    nw  = (len + W - 1) / W;
    pre = pre_in & ((64'd1 << len) - 64'd1);
    exp_chain = '0;
    for (int b = 0; b < len; b++) begin
      wsel = (b < W) ? w0 : w1;
      exp_chain[b] = wsel[b % W];
    end
    pre_val[d] = pre;
    pre_req[d] = 1'b1;
    tick();
    pre_req[d] = 1'b0;
    start_s[d] = 1'b1;
    tick();
    start_s[d] = 1'b0;
    cyc = 1; wp = 0; gap_left = gap; nrb = 0; sc = 0; done_cyc = -1;
    while (cyc <= 300) begin
      if (cen[d]) begin
        wsel = (sc < W) ? w0 : w1;
        chk({tag, "/head"}, 64'(head[d]), 64'(wsel[sc % W]));
        sc++;
      end else begin
        chk({tag, "/head_idle"}, 64'(head[d]), 64'd0);
      end
      if (rbv[d]) begin
        for (int j = 0; j < W; j++) begin
          idx = nrb * W + j;
          exp_rb[j] = (idx < len) ? pre[idx] : 1'b0;
        end
        chk({tag, "/rb_data"}, 64'(rbd[d]), 64'(exp_rb));
        nrb++;
      end
      if (done_s[d]) begin
        done_cyc = cyc;
        break;
      end
      wvalid[d] = 1'b0;
      if (wp < nw) begin
        if (wp == 1 && gap_left > 0 && wready[d]) begin
          gap_left--;
          chk({tag, "/gap_cen"}, 64'(cen[d]), 64'd0);
        end else begin
          wvalid[d] = 1'b1;
          wdata[d]  = (wp == 0) ? w0 : w1;
          if (wready[d]) wp++;
        end
      end
      start_s[d] = spam && busy[d] && (cyc % 7 == 3);
      tick();
      cyc++;
    end
    start_s[d] = 1'b0;
    wvalid[d]  = 1'b0;
    chk({tag, "/done_cycle"}, 64'(done_cyc), 64'(1 + nw + len + gap));
    chk({tag, "/rb_count"}, 64'(nrb), 64'(nw));
    chk({tag, "/shift_count"}, 64'(sc), 64'(len));
    tick();
    chk({tag, "/idle_after_done"}, {62'd0, busy[d], done_s[d]}, 64'd0);
    chk({tag, "/chain"}, chain[d], exp_chain);
  endtask

  int  shifts;
  bit  bad;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; abort_s[i] = 1'b0; wvalid[i] = 1'b0;
      wdata[i] = '0; pre_val[i] = '0; pre_req[i] = 1'b0;
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("reset_flags", {58'd0, wready[i], head[i], cen[i], rbv[i], busy[i], done_s[i]}, 64'd0);
      chk("reset_rb_data", 64'(rbd[i]), 64'd0);
    end
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b1;
    tick();

    run_load(0, 64'hA5_1234_5678, 32'hDEADBEEF, 32'h000000C3, 0, 1'b0, "full40");
    chk("full40/chain_const", chain[0], 64'hC3_DEADBEEF);

    // Reset in cycle 20 of a load
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    wvalid[0]  = 1'b1;
    wdata[0]   = $urandom;
    for (int c = 1; c < 20; c++) tick();
    chk("rst_pre_busy", 64'(busy[0]), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_flags", {58'd0, wready[0], head[0], cen[0], rbv[0], busy[0], done_s[0]}, 64'd0);
    chk("rst_mid_rb_data", 64'(rbd[0]), 64'd0);
    wvalid[0] = 1'b0;
    @(posedge clk);
    #4 rst_n = 1'b1;
    tick();
    chk("rst_release_idle", 64'(busy[0]), 64'd0);

    run_load(0, 64'hA5_1234_5678, 32'hDEADBEEF, 32'h000000C3, 5, 1'b0, "stall40");
    run_load(0, 64'hA5_1234_5678, 32'hDEADBEEF, 32'h000000C3, 0, 1'b1, "spam40");

    // Abort in the 10th SHIFT cycle, with a coincident start that must be ignored
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    shifts = 0;
    bad = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (rbv[0] || done_s[0]) bad = 1'b1;
      if (cen[0]) shifts++;
      if (shifts == 10) break;
      wvalid[0] = 1'b1;
      wdata[0]  = $urandom;
      tick();
    end
    chk("abort_reach", 64'(shifts), 64'd10);
    abort_s[0] = 1'b1;
    start_s[0] = 1'b1;
    tick();
    abort_s[0] = 1'b0;
    start_s[0] = 1'b0;
    wvalid[0]  = 1'b0;
    chk("abort_idle", {62'd0, busy[0], cen[0]}, 64'd0);
    for (int c = 0; c < 5; c++) begin
      if (rbv[0] || done_s[0] || busy[0]) bad = 1'b1;
      tick();
    end
    chk("abort_no_strobe", 64'(bad), 64'd0);
    run_load(0, {$urandom, $urandom}, $urandom, $urandom, 0, 1'b0, "after_abort");

    for (int r = 0; r < 3; r++)
      run_load(0, {$urandom, $urandom}, $urandom, $urandom, $urandom_range(0, 3), r == 1, "rnd40");

    run_load(1, 64'h0123_4567_89AB_CDEF, 32'hCAFEF00D, 32'h13579BDF, 0, 1'b0, "mult64");
    run_load(1, {$urandom, $urandom}, $urandom, $urandom, $urandom_range(0, 4), 1'b1, "rnd64");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ccff_loader.md
# ccff_loader

Serial configuration-chain loader that sits directly upstream of the I/O and logic tiles' configuration flip-flop chain. It accepts bitstream words over a valid/ready handshake, shifts them LSB-first onto `ccff_head` at one bit per `prog_clk`, and drives `config_enable` as the chain-advance qualifier. It simultaneously captures the bits emerging from the chain's `ccff_tail` into readback words, allowing the previous configuration to be verified or saved.

## Interface
Parameters:
- `WORD_W`, 32, bitstream word width.
- `CHAIN_LEN`, 1152, total configuration bits in the chain; must be ≥ 1.
- `CNT_W`, 16, width of the total-bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- `prog_clk`  in  1  programming clock; all state updates on its rising edge.
- `pReset_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  single-cycle pulse; begins a load. Ignored unless in IDLE.
- `abort`  in  1  returns to IDLE next cycle from any state. No `done` is issued.
- `word_data`  in  WORD_W  bitstream word; bit 0 is shifted first.
- `word_valid`  in  1  `word_data` is valid.
- `word_ready`  out  1  loader accepts a word this cycle.
- `ccff_head`  out  1  serial data into the head of the chain.
- `ccff_tail`  in  1  serial data from the tail of the chain.
- `config_enable`  out  1  chain shifts on the rising edges where this signal is 1.
- `rb_data`  out  WORD_W  readback word.
- `rb_valid`  out  1  one-cycle strobe indicating `rb_data` is valid.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle strobe after the last chain bit has shifted.

## Operation
- States are IDLE, LOAD, SHIFT, and DONE.
- **IDLE:** On `start`, the block enters LOAD and clears the total counter `tot` to 0.
- **LOAD:** `word_ready` is 1 (combinational on state). On `word_valid && word_ready`:
  - `word_data` latches into `shreg`.
  - Bit index `bi` is set to 0.
  - `rbreg` clears to 0.
  - State goes to SHIFT.
  - While waiting in LOAD, `config_enable` is 0, so the chain holds.
- **SHIFT:** `config_enable` is 1 and `ccff_head` equals `shreg[0]`. On each edge in SHIFT:
  - `shreg` shifts right, filling with 0.
  - `rbreg[bi]` captures `ccff_tail`.
  - `bi` and `tot` increment.
- **End of a word:** The word ends when `bi == WORD_W-1` or `tot == CHAIN_LEN-1`. On that edge:
  - `rb_data` is loaded with the completed `rbreg`, including the bit captured on that edge.
  - `rb_valid` pulses on the next cycle.
  - State goes to DONE if `tot == CHAIN_LEN-1`, otherwise back to LOAD.
- **Partial last word:** If the last word is partial, its unused high bits are discarded. The corresponding `rb_data` bits above the valid count read 0.
- **DONE:** `done` is 1 for one cycle, then the state goes to IDLE.
- **Readback order:**
  - Readback word k, bit j, is the tail bit that emerged on global shift number k·WORD_W+j.
  - The first CHAIN_LEN tail bits are the previous chain contents, oldest bit first.
- **abort:** Has priority over every other transition. The total counter and word state are discarded, and `rb_valid` is not issued for the partial word. A `start` in the same cycle as `abort` is ignored.
- **Outputs when not in SHIFT:** `ccff_head` is 0.

## Timing
- Reset values: state IDLE; all of `word_ready`, `ccff_head`, `config_enable`, `rb_valid`, `busy`, `done` are 0; `rb_data` is 0.
- `start` is sampled at edge 0; LOAD holds from cycle 1.
- A word accepted at edge n puts SHIFT in cycles n+1 through n+WORD_W.
- The first chain bit is clocked into the chain at edge n+1.
- Back-to-back operation: a full word costs WORD_W SHIFT cycles plus one LOAD cycle. Throughput is WORD_W/(WORD_W+1) bits per clock when `word_valid` is held high.
- `rb_valid` is asserted in the cycle after the word's last SHIFT edge, which is the LOAD or DONE cycle.
- Total time from `start` to `done` with `word_valid` held high: 1 + ceil(CHAIN_LEN/WORD_W)·(1) + CHAIN_LEN cycles. `done` is high in the final cycle.
- `word_valid` may drop at any time; the loader stalls in LOAD with `config_enable` at 0.
- Reset asserted mid-operation forces the reset values asynchronously. Chain contents are then undefined, and a full reload is required.

## Test plan
- **Full load:** WORD_W=32, CHAIN_LEN=40, chain model preloaded with 40'hA5_1234_5678; `start`, then words 32'hDEADBEEF and 32'h000000C3 with `word_valid` held high.
  - Chain holds 40'hC3_DEADBEEF.
  - `rb_data` reads 32'h12345678, then 32'h000000A5.
  - `done` is asserted at cycle 43.
- **Stall:** Same stimulus, with `word_valid` low for 5 cycles between the two words.
  - `config_enable` stays 0 during the gap.
  - Final chain contents are unchanged from the full-load case.
  - `done` is delayed by exactly 5 cycles.
- **Abort:** `abort` asserted in the 10th SHIFT cycle.
  - State returns to IDLE the next cycle.
  - `rb_valid` and `done` are never asserted.
  - A following `start` completes a normal full load.
- **Ignored start:** `start` pulses while `busy` is 1. They have no effect, and the cycle count matches the full-load case.
- **Reset mid-shift:** `pReset_n` low asynchronously in cycle 20.
  - All outputs read 0 immediately.
  - State is IDLE after release.
- **Exact multiple:** CHAIN_LEN=64 with two full words.
  - Two `rb_valid` strobes are issued.
  - No partial masking occurs.
  - `done` is asserted at cycle 67.
